// File: rtl/reorder_buffer_pkg.sv
// Shared types for the Tomasulo reorder buffer and register status table.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_XLEN  = 32;
    localparam int TAG_W     = 4;
    localparam int REG_W     = 5;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic                writes;
        logic                is_branch;
        logic                mispredict;
        logic [REG_W-1:0]    dest;
        logic [ROB_XLEN-1:0] value;
        logic [ROB_XLEN-1:0] target;
    } rob_entry_t;

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] rob;
    } reg_stat_t;

endpackage

// File: rtl/reorder_buffer.sv
// Sixteen-entry circular reorder buffer: in-order allocate, out-of-order CDB capture,
// in-order commit with branch-mispredict flush.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int XLEN = ROB_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic            issue_writes,
    input  logic [4:0]      issue_dest,
    input  logic            issue_is_branch,
    output logic [3:0]      issue_ROB,
    output logic            rob_full,
    input  logic            cdb_valid,
    input  logic [3:0]      cdb_ROB,
    input  logic [XLEN-1:0] cdb_value,
    input  logic            cdb_mispredict,
    input  logic [XLEN-1:0] cdb_target,
    input  logic [3:0]      Q_j,
    input  logic [3:0]      Q_k,
    output logic            j_ready,
    output logic            k_ready,
    output logic [XLEN-1:0] j_value,
    output logic [XLEN-1:0] k_value,
    input  logic            commit_stall,
    output logic            commit_valid,
    output logic            RegWrite,
    output logic [4:0]      commit_dest,
    output logic [3:0]      commit_ROB,
    output logic [XLEN-1:0] commit_value,
    output logic            flush,
    output logic [XLEN-1:0] flush_target
);

    rob_entry_t [ROB_DEPTH-1:0] entries;
    rob_entry_t                 head_e;
    logic [3:0]                 head;
    logic [3:0]                 tail;
    logic [4:0]                 count;
    logic                       alloc;
    logic                       capture;

    assign head_e    = entries[head];
    assign rob_full  = (count == 5'(ROB_DEPTH));
    assign issue_ROB = tail;

    // The count guard keeps a stale ready head from retiring when the buffer is empty.
    assign commit_valid = (count != 5'd0) && head_e.valid && head_e.ready && !commit_stall;
    assign RegWrite     = commit_valid & head_e.writes & ~head_e.is_branch;
    assign flush        = commit_valid & head_e.is_branch & head_e.mispredict;
    assign commit_dest  = head_e.dest;
    assign commit_ROB   = head;
    assign commit_value = head_e.value;
    assign flush_target = head_e.target;

    assign alloc   = issue_valid & ~rob_full & ~flush;
    assign capture = cdb_valid & entries[cdb_ROB].valid;

    always_comb begin
        j_ready = entries[Q_j].ready;
        j_value = entries[Q_j].value;
        k_ready = entries[Q_k].ready;
        k_value = entries[Q_k].value;
        if (cdb_valid && (cdb_ROB == Q_j)) begin
            j_ready = 1'b1;
            j_value = cdb_value;
        end
        if (cdb_valid && (cdb_ROB == Q_k)) begin
            k_ready = 1'b1;
            k_value = cdb_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entries <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (capture) begin
                entries[cdb_ROB].ready      <= 1'b1;
                entries[cdb_ROB].value      <= cdb_value;
                entries[cdb_ROB].mispredict <= cdb_mispredict;
                entries[cdb_ROB].target     <= cdb_target;
            end
            if (flush) begin
                // Only the valid bits are wiped; payload fields are rewritten on allocation.
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    entries[i].valid <= 1'b0;
                end
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (alloc) begin
                    entries[tail].valid     <= 1'b1;
                    entries[tail].ready     <= 1'b0;
                    entries[tail].writes    <= issue_writes;
                    entries[tail].is_branch <= issue_is_branch;
                    entries[tail].dest      <= issue_dest;
                end
                if (commit_valid) begin
                    entries[head].valid <= 1'b0;
                end
                head  <= head + 4'(commit_valid);
                tail  <= tail + 4'(alloc);
                count <= count + 5'(alloc) - 5'(commit_valid);
            end
        end
    end

endmodule
